// File: rtl/fpga_clk_divider.sv
// Multi-channel programmable clock divider.
// Each channel produces a 50%-duty divided clock whose half period (in clk cycles)
// is written at runtime through a valid/ready config port. Ratio changes take effect
// only at a half-period boundary and a disabled channel finishes its high phase
// before stopping, so div_clk_o never glitches.
//
// Ports:
//   clk             fast clock, all logic on posedge
//   rst_sys_in      synchronous active-high reset
//   ch_en_i         per-channel run request
//   cfg_valid_i     config write request
//   cfg_ready_o     config write accepted when valid & ready (combinational)
//   cfg_ch_i        target channel of a config write
//   cfg_half_per_i  new half period (0 is clamped to 1)
//   div_clk_o       divided clock per channel (registered)
//   rise_stb_o      1-cycle pulse in the first cycle div_clk_o is high
//   fall_stb_o      1-cycle pulse in the first cycle div_clk_o is low
//   running_o       channel is counting (RUN or DRAIN)
module fpga_clk_divider #(
  parameter int unsigned NumCh          = 2,
  parameter int unsigned CntWidth       = 8,
  parameter int unsigned DefaultHalfPer = 50,
  localparam int unsigned ChW           = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                clk,
  input  logic                rst_sys_in,
  input  logic [NumCh-1:0]    ch_en_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [ChW-1:0]      cfg_ch_i,
  input  logic [CntWidth-1:0] cfg_half_per_i,
  output logic [NumCh-1:0]    div_clk_o,
  output logic [NumCh-1:0]    rise_stb_o,
  output logic [NumCh-1:0]    fall_stb_o,
  output logic [NumCh-1:0]    running_o
);

  localparam int unsigned PadW = 2 ** ChW;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  logic [NumCh-1:0]    pending;
  logic [PadW-1:0]     pend_pad;
  logic [CntWidth-1:0] cfg_val;

  // Channel indices beyond NumCh read as "not pending"; such writes are dropped.
  always_comb begin
    pend_pad              = '0;
    pend_pad[NumCh-1:0]   = pending;
  end

  assign cfg_ready_o = ~pend_pad[cfg_ch_i];
  assign cfg_val     = (cfg_half_per_i == '0) ? CntWidth'(1) : cfg_half_per_i;

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    ch_state_e           state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] hp_q, hp_d;
    logic [CntWidth-1:0] shadow_q, shadow_d;
    logic                pend_q, pend_d;
    logic                div_q, div_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                run_q, run_d;
    logic                wrap;
    logic                accept;

    // Channel state register
    always_ff @(posedge clk) begin
      if (rst_sys_in) begin
        state_q  <= ST_STOP;
        cnt_q    <= '0;
        hp_q     <= CntWidth'(DefaultHalfPer);
        shadow_q <= '0;
        pend_q   <= 1'b0;
        div_q    <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        run_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        hp_q     <= hp_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        div_q    <= div_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        run_q    <= run_d;
      end
    end

    // Next-state: counting, toggling, drain-to-stop and config application
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hp_d     = hp_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      div_d    = div_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      wrap     = (cnt_q == (hp_q - CntWidth'(1)));
      accept   = cfg_valid_i && (cfg_ch_i == ChW'(i)) && !pend_q;

      unique case (state_q)
        ST_STOP: begin
          cnt_d = '0;
          div_d = 1'b0;
          if (ch_en_i[i]) state_d = ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          if (!ch_en_i[i] && !div_q) begin
            // Low phase: stop immediately, no edge is produced.
            state_d = ST_STOP;
            cnt_d   = '0;
          end else begin
            if (wrap) begin
              cnt_d  = '0;
              div_d  = ~div_q;
              rise_d = ~div_q;
              fall_d = div_q;
              if (pend_q) begin
                hp_d   = shadow_q;
                pend_d = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CntWidth'(1);
            end
            // Disabled while high: finish the high phase, stop on the falling wrap.
            if (ch_en_i[i])  state_d = ST_RUN;
            else if (wrap)   state_d = ST_STOP;
            else             state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_STOP;
          cnt_d   = '0;
          div_d   = 1'b0;
        end
      endcase

      // Stopped channels take the new half period directly; running ones defer it.
      if (accept) begin
        if (state_q == ST_STOP || state_d == ST_STOP) begin
          hp_d = cfg_val;
        end else begin
          shadow_d = cfg_val;
          pend_d   = 1'b1;
        end
      end else if (state_d == ST_STOP && pend_q) begin
        hp_d   = shadow_q;
        pend_d = 1'b0;
      end

      run_d = (state_d != ST_STOP);
    end

    assign pending[i]    = pend_q;
    assign div_clk_o[i]  = div_q;
    assign rise_stb_o[i] = rise_q;
    assign fall_stb_o[i] = fall_q;
    assign running_o[i]  = run_q;
  end

endmodule

// File: tb/tb_fpga_clk_divider.sv
// Directed bench for fpga_clk_divider (NumCh=2, CntWidth=8, DefaultHalfPer=50).
// Inputs change and outputs are sampled 1 time unit after each rising clk edge.
module tb_fpga_clk_divider;

  logic       clk = 1'b0;
  logic       rst_sys_in;
  logic [1:0] ch_en_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [0:0] cfg_ch_i;
  logic [7:0] cfg_half_per_i;
  logic [1:0] div_clk_o;
  logic [1:0] rise_stb_o;
  logic [1:0] fall_stb_o;
  logic [1:0] running_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fpga_clk_divider #(
    .NumCh(2),
    .CntWidth(8),
    .DefaultHalfPer(50)
  ) dut (
    .clk            (clk),
    .rst_sys_in     (rst_sys_in),
    .ch_en_i        (ch_en_i),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_ch_i       (cfg_ch_i),
    .cfg_half_per_i (cfg_half_per_i),
    .div_clk_o      (div_clk_o),
    .rise_stb_o     (rise_stb_o),
    .fall_stb_o     (fall_stb_o),
    .running_o      (running_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Per-channel output snapshot: {div, rise, fall, running}
  function automatic logic [3:0] snap(input int ch);
    return {div_clk_o[ch], rise_stb_o[ch], fall_stb_o[ch], running_o[ch]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_sys_in     = 1'b1;
    ch_en_i        = 2'b00;
    cfg_valid_i    = 1'b0;
    cfg_ch_i       = 1'b0;
    cfg_half_per_i = 8'd0;
    step(2);

    // T1 reset state, first rise 50 cycles after enable, period 100
    check("rst_ch0",   32'(snap(0)), 32'h0);
    check("rst_ch1",   32'(snap(1)), 32'h0);
    check("rst_ready", 32'(cfg_ready_o), 32'h1);
    rst_sys_in = 1'b0;
    ch_en_i[0] = 1'b1;
    step(1);
    check("t1_en",       32'(snap(0)), 32'b0001);
    step(49);
    check("t1_pre_rise", 32'(snap(0)), 32'b0001);
    step(1);
    check("t1_rise",     32'(snap(0)), 32'b1101);
    step(1);
    check("t1_high",     32'(snap(0)), 32'b1001);
    step(48);
    check("t1_pre_fall", 32'(snap(0)), 32'b1001);
    step(1);
    check("t1_fall",     32'(snap(0)), 32'b0011);
    step(1);
    check("t1_low",      32'(snap(0)), 32'b0001);
    step(49);
    check("t1_rise2",    32'(snap(0)), 32'b1101);

    // T3 disable while high at cnt=5: drain to the falling wrap
    step(5);
    ch_en_i[0] = 1'b0;
    step(1);
    check("t3_drain",    32'(snap(0)), 32'b1001);
    step(43);
    check("t3_pre_fall", 32'(snap(0)), 32'b1001);
    step(1);
    check("t3_fall",     32'(snap(0)), 32'b0010);
    step(10);
    check("t3_held",     32'(snap(0)), 32'b0000);

    // T4 hp=0 to stopped ch0 clamps to 1: divide-by-2
    cfg_valid_i    = 1'b1;
    cfg_ch_i       = 1'b0;
    cfg_half_per_i = 8'd0;
    #1;
    check("t4_ready", 32'(cfg_ready_o), 32'h1);
    step(1);
    cfg_valid_i = 1'b0;
    ch_en_i[0]  = 1'b1;
    step(1);
    check("t4_en",    32'(snap(0)), 32'b0001);
    step(1);
    check("t4_rise",  32'(snap(0)), 32'b1101);
    step(1);
    check("t4_fall",  32'(snap(0)), 32'b0011);
    step(1);
    check("t4_rise2", 32'(snap(0)), 32'b1101);
    ch_en_i[0] = 1'b0;
    step(1);
    check("t4_stop",  32'(snap(0)), 32'b0010);

    // T5 hp=4 written in the wrap cycle: next half still 50, then 4
    cfg_valid_i    = 1'b1;
    cfg_half_per_i = 8'd50;
    step(1);
    cfg_valid_i = 1'b0;
    ch_en_i[0]  = 1'b1;
    step(50);
    cfg_valid_i    = 1'b1;
    cfg_half_per_i = 8'd4;
    #1;
    check("t5_ready_wrap", 32'(cfg_ready_o), 32'h1);
    step(1);
    cfg_valid_i = 1'b0;
    #1;
    check("t5_rise",       32'(snap(0)), 32'b1101);
    check("t5_pending",    32'(cfg_ready_o), 32'h0);
    step(49);
    check("t5_still50",    32'(snap(0)), 32'b1001);
    step(1);
    check("t5_fall",       32'(snap(0)), 32'b0011);
    check("t5_applied",    32'(cfg_ready_o), 32'h1);
    step(3);
    check("t5_low4",       32'(snap(0)), 32'b0001);
    step(1);
    check("t5_rise4",      32'(snap(0)), 32'b1101);
    step(4);
    check("t5_fall4",      32'(snap(0)), 32'b0011);

    // T6 reset while high with a pending write
    step(4);
    check("t6_high", 32'(snap(0)), 32'b1101);
    cfg_valid_i    = 1'b1;
    cfg_half_per_i = 8'd9;
    step(1);
    cfg_valid_i = 1'b0;
    #1;
    check("t6_pend", 32'(cfg_ready_o), 32'h0);
    rst_sys_in = 1'b1;
    step(1);
    check("t6_rst_out",   32'(snap(0)), 32'b0000);
    check("t6_rst_ready", 32'(cfg_ready_o), 32'h1);
    rst_sys_in = 1'b0;
    step(1);
    check("t6_restart",   32'(snap(0)), 32'b0001);
    step(49);
    check("t6_pre_rise",  32'(snap(0)), 32'b0001);
    step(1);
    check("t6_hp50",      32'(snap(0)), 32'b1101);

    // T2 ch1 running hp=50, write hp=3 at cnt=10, second write stalls
    ch_en_i[1] = 1'b1;
    step(11);
    cfg_valid_i    = 1'b1;
    cfg_ch_i       = 1'b1;
    cfg_half_per_i = 8'd3;
    #1;
    check("t2_ready0", 32'(cfg_ready_o), 32'h1);
    step(1);
    cfg_half_per_i = 8'd7;
    #1;
    check("t2_stall", 32'(cfg_ready_o), 32'h0);
    begin
      int stalls;
      stalls = 0;
      for (int k = 0; k < 38; k++) begin
        step(1);
        if (cfg_ready_o !== 1'b0) stalls++;
      end
      check("t2_stall_run", 32'(stalls), 32'd0);
    end
    check("t2_pre_wrap", 32'(snap(1)), 32'b0001);
    cfg_valid_i = 1'b0;
    cfg_ch_i    = 1'b0;
    #1;
    check("t2_ch0_ready", 32'(cfg_ready_o), 32'h1);
    cfg_ch_i = 1'b1;
    step(1);
    check("t2_rise",     32'(snap(1)), 32'b1101);
    check("t2_ready1",   32'(cfg_ready_o), 32'h1);
    step(2);
    check("t2_high3",    32'(snap(1)), 32'b1001);
    step(1);
    check("t2_fall3",    32'(snap(1)), 32'b0011);
    step(2);
    check("t2_low3",     32'(snap(1)), 32'b0001);
    step(1);
    check("t2_rise3",    32'(snap(1)), 32'b1101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
